dpcm_decoder: RTL and testbench

- Downstream stage of the 4-bit DPCM encoder: consumes difference codes, reconstructs the original samples by modulo-2^WIDTH accumulation.
- Small input FIFO absorbs bursts.
- Registered output stage with valid/ready handshake to the sink.
- Lossless inverse of the encoder: sample = previous + diff (mod 2^WIDTH).

---
 rtl/dpcm_decoder.sv | 126 ++++++++++++
 tb/tb_dpcm_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpcm_decoder.sv
// dpcm_decoder: rebuilds samples from 4-bit DPCM difference codes.
// Incoming {resync, diff} pairs are buffered in a small FIFO. The output
// stage pops one entry at a time, adds it to the previous sample modulo
// 2^WIDTH, and presents the result through a valid/ready register.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   diff/resync valid
//   in_ready   FIFO not full (combinational from level)
//   diff       difference code
//   resync     decode this diff against previous = 0
//   out_valid  sample register holds a valid sample
//   out_ready  sink accepts sample
//   sample     reconstructed sample
//   level      FIFO occupancy, 0..DEPTH
module dpcm_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         diff,
  input  logic                     resync,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sample,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [LW-1:0]     level_q;
  logic [WIDTH-1:0]  sample_q;

  logic              push_c;
  logic              pop_c;
  logic              empty_c;
  logic [EW-1:0]     head_c;
  logic [WIDTH-1:0]  base_c;
  logic [WIDTH-1:0]  recon_c;

  // FIFO flags; a full FIFO refuses pushes even when a pop happens this cycle
  assign empty_c  = (level_q == '0);
  assign in_ready = (level_q != LW'(DEPTH));
  assign push_c   = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty_c) state_d = VALID;
      VALID: if (out_ready && empty_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop whenever the output register is free or being drained
  always_comb begin
    pop_c = 1'b0;
    unique case (state_q)
      IDLE:  pop_c = !empty_c;
      VALID: pop_c = out_ready && !empty_c;
      default: pop_c = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset because level gates every read
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wptr_q] <= {resync, diff};
    end
  end

  // Reconstruction: the sample register doubles as the predictor state
  assign head_c  = mem[rptr_q];
  assign base_c  = head_c[WIDTH] ? '0 : sample_q;
  assign recon_c = base_c + head_c[WIDTH-1:0];

  // Pointers, occupancy and sample register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      sample_q <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + AW'(1);
      if (pop_c) begin
        rptr_q   <= rptr_q + AW'(1);
        sample_q <= recon_c;
      end
      unique case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign out_valid = (state_q == VALID);
  assign sample    = sample_q;
  assign level     = level_q;

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed bench for dpcm_decoder (WIDTH=4, DEPTH=4) with hand-computed
// expected samples, occupancy and handshake flags.
module tb_dpcm_decoder;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] diff;
  logic       resync;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sample;
  logic [2:0] level;

  int n_cmp = 0;
  int n_err = 0;
  int accepted;
  int got[$];
  int exp_v[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_s[9] = '{0, 2, 4, 4, 6, 6, 8, 8, 0};

  dpcm_decoder #(.WIDTH(4), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .resync    (resync),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sample    (sample),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int s);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sample"}, 32'(sample), 32'(s));
  endtask

  // Reset pulse placed between clock edges
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    diff      = '0;
    resync    = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sample",    32'(sample),    32'd0);
    reset = 1'b1;
    tick();

    // Basic round trip: diffs 3,4,0,11 -> samples 3,7,7,2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    diff      = 4'd3;
    tick();
    chk("rt_lat_valid", 32'(out_valid), 32'd0);
    chk("rt_lat_level", 32'(level), 32'd1);
    diff = 4'd4;
    tick();
    expect_out("rt_s0", 3);
    diff = 4'd0;
    tick();
    expect_out("rt_s1", 7);
    diff = 4'd11;
    tick();
    expect_out("rt_s2", 7);
    in_valid = 1'b0;
    tick();
    expect_out("rt_s3", 2);
    chk("rt_level_end", 32'(level), 32'd0);
    tick();
    chk("rt_idle", 32'(out_valid), 32'd0);

    // Wrap-around: from 2, diffs 13,1,15 -> 15,0,15
    in_valid = 1'b1;
    diff     = 4'd13;
    tick();
    diff = 4'd1;
    tick();
    expect_out("wrap_15", 15);
    diff = 4'd15;
    tick();
    expect_out("wrap_0", 0);
    in_valid = 1'b0;
    tick();
    expect_out("wrap_15b", 15);
    tick();
    chk("wrap_idle", 32'(out_valid), 32'd0);

    // Backpressure / full: six offers of diff 1 with out_ready=0
    pulse_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    diff      = 4'd1;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    chk("full_accepted", 32'(accepted), 32'd5);
    chk("full_level",    32'(level),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    expect_out("full_hold0", 1);
    tick();
    expect_out("full_hold1", 1);
    chk("full_level_hold", 32'(level), 32'd4);
    out_ready = 1'b1;
    tick();
    expect_out("drain_2", 2);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_level", 32'(level), 32'd3);
    tick();
    expect_out("drain_3", 3);
    tick();
    expect_out("drain_4", 4);
    tick();
    expect_out("drain_5", 5);
    tick();
    chk("drain_idle", 32'(out_valid), 32'd0);

    // Resync: 5+2=7, resync diff 9 -> 9, then diff 2 -> 11
    in_valid = 1'b1;
    diff     = 4'd2;
    resync   = 1'b0;
    tick();
    diff   = 4'd9;
    resync = 1'b1;
    tick();
    expect_out("rs_7", 7);
    diff   = 4'd2;
    resync = 1'b0;
    tick();
    expect_out("rs_9", 9);
    in_valid = 1'b0;
    tick();
    expect_out("rs_11", 11);
    tick();
    chk("rs_idle", 32'(out_valid), 32'd0);

    // Async reset mid-stream with level=3
    out_ready = 1'b0;
    in_valid  = 1'b1;
    diff      = 4'd1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("ar_level_pre", 32'(level), 32'd3);
    expect_out("ar_pre", 12);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_level",     32'(level),     32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    chk("ar_sample",    32'(sample),    32'd0);
    #1;
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    diff      = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    expect_out("ar_post", 5);
    tick();
    chk("ar_idle", 32'(out_valid), 32'd0);

    // Stall toggling: diffs 2,2,2,2 with out_ready 1,0,1,0,...
    pulse_reset();
    diff = 4'd2;
    got.delete();
    for (int k = 0; k < 9; k++) begin
      out_ready = (k % 2 == 0);
      in_valid  = (k < 4);
      if (out_valid && out_ready) got.push_back(int'(sample));
      tick();
      chk($sformatf("stall_v%0d", k), 32'(out_valid), 32'(exp_v[k]));
      if (exp_v[k] == 1) chk($sformatf("stall_s%0d", k), 32'(sample), 32'(exp_s[k]));
    end
    chk("stall_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("stall_got%0d", i), 32'(got[i]), 32'(2 * (i + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
